// File: rtl/gullfaxi_arbiter.sv
// Three-way round-robin packet arbiter: grants one requester at a time and merges
// its byte stream onto a single registered output with length and timeout checking.
//   state   | meaning
//   IDLE    | no grant; pick next requester when the sink is ready
//   GRANTED | grant held, waiting for the requester's first byte
//   XFER    | forwarding bytes until R_end or the declared length
module gullfaxi_arbiter #(
    parameter int START_TIMEOUT = 8,
    parameter int NREQ          = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      R_req,
    input  logic [2:0][5:0] R_length,
    input  logic [2:0]      R_start,
    input  logic [2:0]      R_end,
    input  logic [2:0][7:0] R_data,
    output logic [2:0]      R_grant,
    input  logic            Q_ready,
    output logic            Q_valid,
    output logic            Q_start,
    output logic            Q_end,
    output logic [7:0]      Q_data,
    output logic [5:0]      Q_length,
    output logic [1:0]      Q_src,
    output logic            err_len,
    output logic            err_timeout
);

    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        XFER    = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    sel;
    logic [1:0]    last_winner;
    logic [5:0]    len_reg;
    logic [5:0]    byte_cnt;
    logic [TW-1:0] wait_cnt;

    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic [TW-1:0] wait_nxt;
    logic [5:0]    byte_nxt;

    assign wait_nxt = wait_cnt + TW'(1);
    assign byte_nxt = byte_cnt + 6'd1;

    // First requesting index after the previous winner, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!pick_valid && R_req[(int'(last_winner) + i) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = 2'((int'(last_winner) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sel         <= 2'd0;
            last_winner <= 2'd2;
            len_reg     <= 6'd0;
            byte_cnt    <= 6'd0;
            wait_cnt    <= '0;
            R_grant     <= 3'b000;
            Q_valid     <= 1'b0;
            Q_start     <= 1'b0;
            Q_end       <= 1'b0;
            Q_data      <= 8'd0;
            Q_length    <= 6'd0;
            Q_src       <= 2'd0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            Q_valid     <= 1'b0;
            Q_start     <= 1'b0;
            Q_end       <= 1'b0;
            Q_data      <= 8'd0;
            Q_length    <= 6'd0;
            Q_src       <= 2'd0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid && Q_ready) begin
                        sel      <= pick_idx;
                        len_reg  <= R_length[pick_idx];
                        R_grant  <= 3'b001 << pick_idx;
                        wait_cnt <= '0;
                        byte_cnt <= 6'd0;
                        state    <= GRANTED;
                    end else begin
                        R_grant <= 3'b000;
                    end
                end

                GRANTED: begin
                    if (R_start[sel]) begin
                        Q_valid  <= 1'b1;
                        Q_start  <= 1'b1;
                        Q_data   <= R_data[sel];
                        Q_length <= len_reg;
                        Q_src    <= sel;
                        byte_cnt <= 6'd1;
                        // A one-byte packet can finish on its start cycle.
                        if (R_end[sel] || len_reg == 6'd1) begin
                            Q_end       <= 1'b1;
                            err_len     <= !(R_end[sel] && len_reg == 6'd1);
                            R_grant     <= 3'b000;
                            last_winner <= sel;
                            byte_cnt    <= 6'd0;
                            state       <= IDLE;
                        end else begin
                            state <= XFER;
                        end
                    end else if (wait_nxt == TW'(START_TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        R_grant     <= 3'b000;
                        last_winner <= sel;
                        wait_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end

                XFER: begin
                    Q_valid  <= 1'b1;
                    Q_data   <= R_data[sel];
                    Q_length <= len_reg;
                    Q_src    <= sel;
                    if (R_end[sel] || byte_nxt == len_reg) begin
                        Q_end       <= 1'b1;
                        err_len     <= !(R_end[sel] && byte_nxt == len_reg);
                        R_grant     <= 3'b000;
                        last_winner <= sel;
                        byte_cnt    <= 6'd0;
                        wait_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        byte_cnt <= byte_nxt;
                    end
                end

                default: begin
                    R_grant <= 3'b000;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gullfaxi_arbiter.sv
// Directed bench for gullfaxi_arbiter: inputs change and outputs are sampled on the
// falling clock edge, expected values are written out per scenario.
module tb_gullfaxi_arbiter;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      R_req;
    logic [2:0][5:0] R_length;
    logic [2:0]      R_start;
    logic [2:0]      R_end;
    logic [2:0][7:0] R_data;
    logic [2:0]      R_grant;
    logic            Q_ready;
    logic            Q_valid;
    logic            Q_start;
    logic            Q_end;
    logic [7:0]      Q_data;
    logic [5:0]      Q_length;
    logic [1:0]      Q_src;
    logic            err_len;
    logic            err_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    logic       lg_valid [8];
    logic       lg_start [8];
    logic       lg_end   [8];
    logic       lg_err   [8];
    logic [7:0] lg_data  [8];
    logic [5:0] lg_len   [8];
    logic [1:0] lg_src   [8];
    logic [2:0] lg_grant [8];

    gullfaxi_arbiter #(.START_TIMEOUT(8), .NREQ(3)) dut (
        .clk(clk), .reset(reset),
        .R_req(R_req), .R_length(R_length), .R_start(R_start), .R_end(R_end),
        .R_data(R_data), .R_grant(R_grant), .Q_ready(Q_ready),
        .Q_valid(Q_valid), .Q_start(Q_start), .Q_end(Q_end), .Q_data(Q_data),
        .Q_length(Q_length), .Q_src(Q_src),
        .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_data(input int idx, input int k);
        return 8'h40 + 8'(idx * 16) + 8'(k);
    endfunction

    task automatic do_reset();
        reset    = 1'b0;
        R_req    = 3'b000;
        R_length = '0;
        R_start  = 3'b000;
        R_end    = 3'b000;
        R_data   = '0;
        Q_ready  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_grant(output logic [2:0] g, output int cycles);
        g      = 3'b000;
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (R_grant !== 3'b000) begin
                g = R_grant;
                break;
            end
        end
    endtask

    // Streams nbytes for requester idx while the other requesters drive junk,
    // logging the merged output one cycle after each byte.
    task automatic stream(input int idx, input int nbytes, input bit with_end);
        for (int k = 0; k < nbytes; k++) begin
            for (int j = 0; j < 3; j++) begin
                if (j == idx) begin
                    R_start[j] = (k == 0);
                    R_end[j]   = with_end && (k == nbytes - 1);
                    R_data[j]  = exp_data(idx, k);
                end else begin
                    R_start[j] = 1'b1;
                    R_end[j]   = 1'b1;
                    R_data[j]  = 8'hFF;
                end
            end
            @(negedge clk);
            lg_valid[k] = Q_valid;
            lg_start[k] = Q_start;
            lg_end[k]   = Q_end;
            lg_err[k]   = err_len;
            lg_data[k]  = Q_data;
            lg_len[k]   = Q_length;
            lg_src[k]   = Q_src;
            lg_grant[k] = R_grant;
        end
        R_start = 3'b000;
        R_end   = 3'b000;
        R_data  = '0;
    endtask

    task automatic test_reset();
        logic [20:0] act;
        reset   = 1'b0;
        R_req   = 3'b111;
        Q_ready = 1'b1;
        repeat (2) @(negedge clk);
        act = {R_grant, Q_valid, Q_start, Q_end, Q_data, Q_length[1:0], Q_src, err_len, err_timeout, Q_length[5:2]};
        n_checks++;
        if (act !== 21'd0) $display("FAIL reset_outputs: got %h want 0", act); else n_pass++;
        do_reset();
        @(negedge clk);
        n_checks++;
        if (R_grant !== 3'b000) $display("FAIL reset_release_grant: got %b want 000", R_grant); else n_pass++;
    endtask

    task automatic test_single();
        logic [2:0]  g;
        int          c;
        logic [19:0] act, exp;
        do_reset();
        R_req       = 3'b010;
        R_length[1] = 6'd4;
        wait_grant(g, c);
        R_req = 3'b000;
        n_checks++;
        if (g !== 3'b010) $display("FAIL single_grant: got %b want 010", g); else n_pass++;
        n_checks++;
        if (c != 1) $display("FAIL single_grant_latency: got %0d want 1", c); else n_pass++;
        stream(1, 4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            act = {lg_valid[k], lg_start[k], lg_end[k], lg_err[k], lg_data[k], lg_len[k], lg_src[k]};
            exp = {1'b1, k == 0, k == 3, 1'b0, exp_data(1, k), 6'd4, 2'd1};
            n_checks++;
            if (act !== exp) $display("FAIL single_byte%0d: got %h want %h", k, act, exp); else n_pass++;
        end
        n_checks++;
        if (lg_grant[3] !== 3'b000) $display("FAIL single_grant_drop: got %b want 000", lg_grant[3]); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (Q_valid !== 1'b0) $display("FAIL single_after_valid: got %b want 0", Q_valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [2:0] g;
        int         c;
        int         order [4] = '{0, 1, 2, 0};
        do_reset();
        R_req    = 3'b111;
        R_length = {6'd2, 6'd2, 6'd2};
        for (int n = 0; n < 4; n++) begin
            wait_grant(g, c);
            n_checks++;
            if (g !== (3'b001 << order[n])) $display("FAIL rr_grant%0d: got %b want %b", n, g, 3'b001 << order[n]); else n_pass++;
            n_checks++;
            if (c != 1) $display("FAIL rr_gap%0d: got %0d cycles want 1", n, c); else n_pass++;
            stream(order[n], 2, 1'b1);
            n_checks++;
            if ({lg_end[1], lg_err[1], lg_src[1], lg_grant[1]} !== {1'b1, 1'b0, 2'(order[n]), 3'b000})
                $display("FAIL rr_pkt%0d: got end=%b err=%b src=%0d grant=%b want end=1 err=0 src=%0d grant=000",
                         n, lg_end[1], lg_err[1], lg_src[1], lg_grant[1], order[n]);
            else n_pass++;
        end
        R_req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [2:0] g;
        int         c;
        int         to_at   = -1;
        int         drop_at = -1;
        logic       saw_len = 1'b0;
        do_reset();
        R_req       = 3'b100;
        R_length[2] = 6'd5;
        wait_grant(g, c);
        R_req = 3'b000;
        n_checks++;
        if (g !== 3'b100) $display("FAIL timeout_grant: got %b want 100", g); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1 && to_at < 0) to_at = i;
            if (R_grant === 3'b000 && drop_at < 0) drop_at = i;
            if (err_len !== 1'b0) saw_len = 1'b1;
        end
        n_checks++;
        if (to_at != 8) $display("FAIL timeout_pulse_cycle: got %0d want 8", to_at); else n_pass++;
        n_checks++;
        if (drop_at != 8) $display("FAIL timeout_grant_drop: got %0d want 8", drop_at); else n_pass++;
        n_checks++;
        if (saw_len !== 1'b0) $display("FAIL timeout_no_err_len: got %b want 0", saw_len); else n_pass++;
        R_req    = 3'b111;
        R_length = {6'd1, 6'd1, 6'd1};
        wait_grant(g, c);
        R_req = 3'b000;
        n_checks++;
        if (g !== 3'b001 || c != 1) $display("FAIL timeout_next_grant: got %b after %0d want 001 after 1", g, c); else n_pass++;
        stream(0, 1, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_length_errors();
        logic [2:0] g;
        int         c;
        do_reset();
        R_req       = 3'b010;
        R_length[1] = 6'd3;
        wait_grant(g, c);
        R_req = 3'b000;
        stream(1, 2, 1'b1);
        n_checks++;
        if ({lg_valid[0], lg_start[0], lg_err[0]} !== 3'b110) $display("FAIL early_end_first: got %b want 110", {lg_valid[0], lg_start[0], lg_err[0]}); else n_pass++;
        n_checks++;
        if ({lg_end[1], lg_err[1]} !== 2'b11) $display("FAIL early_end_err: got end=%b err=%b want 1 1", lg_end[1], lg_err[1]); else n_pass++;
        n_checks++;
        if ({lg_data[1], lg_len[1], lg_src[1]} !== {exp_data(1, 1), 6'd3, 2'd1})
            $display("FAIL early_end_fields: got data=%h len=%0d src=%0d want %h 3 1", lg_data[1], lg_len[1], lg_src[1], exp_data(1, 1));
        else n_pass++;

        R_req = 3'b010;
        wait_grant(g, c);
        R_req = 3'b000;
        n_checks++;
        if (g !== 3'b010) $display("FAIL forced_end_grant: got %b want 010", g); else n_pass++;
        stream(1, 4, 1'b0);
        n_checks++;
        if ({lg_end[1], lg_err[1]} !== 2'b00) $display("FAIL forced_end_byte2: got end=%b err=%b want 0 0", lg_end[1], lg_err[1]); else n_pass++;
        n_checks++;
        if ({lg_valid[2], lg_end[2], lg_err[2]} !== 3'b111) $display("FAIL forced_end_byte3: got %b want 111", {lg_valid[2], lg_end[2], lg_err[2]}); else n_pass++;
        n_checks++;
        if ({lg_valid[3], lg_err[3], lg_grant[2]} !== {1'b0, 1'b0, 3'b000}) $display("FAIL forced_end_after: got valid=%b err=%b grant=%b want 0 0 000", lg_valid[3], lg_err[3], lg_grant[2]); else n_pass++;
    endtask

    task automatic test_len1();
        logic [2:0] g;
        int         c;
        do_reset();
        R_req       = 3'b001;
        R_length[0] = 6'd1;
        wait_grant(g, c);
        R_req = 3'b000;
        stream(0, 1, 1'b1);
        n_checks++;
        if ({lg_valid[0], lg_start[0], lg_end[0], lg_err[0]} !== 4'b1110)
            $display("FAIL len1_byte: got %b want 1110", {lg_valid[0], lg_start[0], lg_end[0], lg_err[0]});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (Q_valid !== 1'b0) $display("FAIL len1_single: got valid=%b want 0", Q_valid); else n_pass++;
    endtask

    task automatic test_ready();
        logic [2:0] g;
        int         c;
        logic       saw = 1'b0;
        do_reset();
        Q_ready     = 1'b0;
        R_req       = 3'b010;
        R_length[1] = 6'd3;
        repeat (6) begin
            @(negedge clk);
            if (R_grant !== 3'b000) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) $display("FAIL ready_low_grant: got %b want 0", saw); else n_pass++;
        Q_ready = 1'b1;
        wait_grant(g, c);
        R_req   = 3'b000;
        Q_ready = 1'b0;
        n_checks++;
        if (g !== 3'b010 || c != 1) $display("FAIL ready_high_grant: got %b after %0d want 010 after 1", g, c); else n_pass++;
        stream(1, 3, 1'b1);
        n_checks++;
        if ({lg_valid[2], lg_end[2], lg_err[2]} !== 3'b110) $display("FAIL ready_drop_xfer: got %b want 110", {lg_valid[2], lg_end[2], lg_err[2]}); else n_pass++;
        Q_ready = 1'b1;
    endtask

    task automatic test_reset_mid_xfer();
        logic [2:0] g;
        int         c;
        do_reset();
        R_req       = 3'b001;
        R_length[0] = 6'd5;
        wait_grant(g, c);
        R_req      = 3'b000;
        R_start[0] = 1'b1;
        R_data[0]  = exp_data(0, 0);
        @(negedge clk);
        R_start[0] = 1'b0;
        R_data[0]  = exp_data(0, 1);
        @(negedge clk);
        n_checks++;
        if ({Q_valid, R_grant} !== 4'b1001) $display("FAIL midreset_pre: got valid=%b grant=%b want 1 001", Q_valid, R_grant); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({R_grant, Q_valid, Q_start, Q_end, Q_data, Q_length, Q_src, err_len, err_timeout} !== 25'd0)
            $display("FAIL midreset_outputs: got grant=%b valid=%b data=%h len=%0d", R_grant, Q_valid, Q_data, Q_length);
        else n_pass++;
        @(negedge clk);
        R_data      = '0;
        R_length[0] = 6'd1;
        reset       = 1'b1;
        R_req       = 3'b011;
        wait_grant(g, c);
        R_req = 3'b000;
        n_checks++;
        if (g !== 3'b001 || c != 1) $display("FAIL midreset_regrant: got %b after %0d want 001 after 1", g, c); else n_pass++;
        n_checks++;
        if (Q_valid !== 1'b0) $display("FAIL midreset_no_partial: got valid=%b want 0", Q_valid); else n_pass++;
        stream(0, 1, 1'b1);
        n_checks++;
        if ({lg_valid[0], lg_start[0], lg_end[0], lg_err[0]} !== 4'b1110)
            $display("FAIL midreset_clean_pkt: got %b want 1110", {lg_valid[0], lg_start[0], lg_end[0], lg_err[0]});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_length_errors();
        test_len1();
        test_ready();
        test_reset_mid_xfer();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gullfaxi_arbiter.md
GULLFAXI_ARBITER -- requirements
Module: gullfaxi_arbiter

Interface
REQ-001 Parameter: START_TIMEOUT, default 8, max cycles from grant to the granted requester's start before the grant is revoked.
REQ-002 Parameter: NREQ, default 3, number of requesters; fixed at 3 in this release.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 R_req  input  [2:0]  per-requester request, held by the requester until granted.
REQ-006 R_length  input  [2:0][5:0]  per-requester packet length in bytes (1..63), valid while R_req is high.
REQ-007 R_start / R_end  input  [2:0] each  first-byte and last-byte markers of the requester's data stream.
REQ-008 R_data  input  [2:0][7:0]  per-requester data bytes.
REQ-009 R_grant  output  [2:0]  one-hot grant; at most one bit high.
REQ-010 Q_ready  input  1  sink admits a new packet; sampled only when issuing a grant.
REQ-011 Q_valid, Q_start, Q_end  output  1 each  merged-stream byte-valid, first-byte and last-byte markers.
REQ-012 Q_data  output  8  merged data byte.
REQ-013 Q_length  output  6  length of the packet in flight, valid while Q_valid is high.
REQ-014 Q_src  output  2  index of the requester owning the packet in flight.
REQ-015 err_len  output  1  one-cycle pulse on a length/end mismatch.
REQ-016 err_timeout  output  1  one-cycle pulse on a grant timeout.

Function
REQ-017 FSM states: IDLE, GRANTED, XFER.
REQ-018 IDLE: if any R_req bit is high and Q_ready=1, select a requester round-robin starting at (last_winner+1) mod 3; register its index and R_length; set its R_grant bit; go to GRANTED. Otherwise stay in IDLE with R_grant=0.
REQ-019 R_grant shall stay high from GRANTED entry until the FSM returns to IDLE, independent of R_req, which the requester drops after sampling the grant.
REQ-020 GRANTED: increment a wait counter each cycle; on R_start[sel]=1 go to XFER; if the counter reaches START_TIMEOUT first, pulse err_timeout, drop the grant, update last_winner and return to IDLE.
REQ-021 In GRANTED and XFER, only the granted requester's inputs are observed; R_start/R_end/R_data from other requesters are ignored.
REQ-022 Datapath: exactly one register stage. Q_valid/Q_data/Q_start/Q_end/Q_length/Q_src in cycle n+1 reflect the granted requester's byte in cycle n; all other cycles drive Q_* to 0.
REQ-023 A byte counts as valid on the start cycle and every following cycle up to and including the R_end cycle; the requester streams with no gaps.
REQ-024 A 6-bit byte counter starts at 1 on R_start and increments per byte; if R_end and R_start occur in the same cycle, the packet has length 1.
REQ-025 On R_end[sel]: if count != registered length, pulse err_len in the same cycle as Q_end; in either case drop the grant, set last_winner=sel, and return to IDLE.
REQ-026 While in XFER, if count reaches the registered length without R_end, force Q_end=1 on that byte, pulse err_len, and return to IDLE; no further bytes are forwarded.
REQ-027 A new grant may be issued in the cycle after leaving XFER, giving a minimum of one idle cycle between packets on R_grant.
REQ-028 If Q_ready falls during GRANTED or XFER, the transfer continues.
REQ-029 err_len and err_timeout are never both high in the same cycle.

Reset
REQ-030 While reset=0: FSM=IDLE, last_winner=2 (so requester 0 wins first), counters=0, and R_grant, Q_*, err_len and err_timeout all 0.
REQ-031 Reset asserted mid-transfer shall drop R_grant and the Q outputs immediately; after release the block resumes from IDLE with no partial packet emitted.

Verification
REQ-032 Single req on 1 with length 4, Q_ready=1: grant1 the cycle after req; Q_start..Q_end span 4 bytes with Q_src=1 and Q_length=4; no errors.
REQ-033 All three requesters hold req continuously with length 2: grants follow 0,1,2,0 with one idle cycle between grants.
REQ-034 Granted requester 2 never starts, START_TIMEOUT=8: err_timeout pulses 8 cycles after grant; the next grant goes to requester 0.
REQ-035 Length 3 declared, R_end on byte 2: err_len coincides with Q_end on the 2nd byte. Length 3 declared, no R_end: Q_end is forced on the 3rd byte and err_len pulses.
REQ-036 Length 1 packet (start and end in the same cycle): exactly one Q byte with Q_start=Q_end=1.
REQ-037 Q_ready=0 with reqs pending: no grant is issued. Reset pulse during XFER: all outputs are 0 within the reset cycle, and a clean re-grant to requester 0 follows.
